// File: rtl/aux_msg_arbiter_mux.sv
// aux_msg_arbiter_mux: round-robin N-channel byte mux that locks its grant for a whole message
module aux_msg_arbiter_mux #(
   parameter int DATA_W      = 8,
   parameter int NUM_CH      = 2,
   parameter int SEL_W       = $clog2(NUM_CH),
   parameter int GAP_TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_vld,
   input  logic [NUM_CH-1:0]        ch_last,
   output logic [NUM_CH-1:0]        ch_rdy,
   input  logic                     force_en,
   input  logic [SEL_W-1:0]         force_sel,
   output logic [DATA_W-1:0]        mux_aux_out,
   output logic                     mux_aux_out_vld,
   output logic                     mux_aux_out_last,
   output logic [SEL_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     abort
);
   localparam int GW = $clog2(GAP_TIMEOUT + 1);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t            state, state_nx;
   logic [SEL_W-1:0]  rr_ptr, win, sel, idx;
   logic [NUM_CH-1:0] elig;
   logic [DATA_W-1:0] sel_data;
   logic [GW-1:0]     gap_cnt;
   logic              found, acc, timeout;

   // eligible set (optionally forced) and first eligible channel after rr_ptr
   always_comb begin
      elig  = '0;
      win   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         elig[i] = ch_vld[i] && (!force_en || force_sel == SEL_W'(i));
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // ready/accept for the owner (locked) or the fresh winner (idle), gap timeout, next state
   always_comb begin
      state_nx = state;
      ch_rdy   = '0;
      sel_data = '0;
      sel      = (state == LOCKED) ? grant_id : win;
      for (int i = 0; i < NUM_CH; i++)
         if (SEL_W'(i) == sel) sel_data = ch_data[i*DATA_W +: DATA_W];
      if (state == LOCKED || found) ch_rdy[sel] = 1'b1;
      acc     = ch_vld[sel] && (state == LOCKED || found);
      timeout = (state == LOCKED) && !ch_vld[sel] && gap_cnt == GW'(GAP_TIMEOUT - 1);
      if (acc) state_nx = ch_last[sel] ? IDLE : LOCKED;
      else if (timeout) state_nx = IDLE;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;

   // registered output byte, grant bookkeeping and idle-gap counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rr_ptr           <= SEL_W'(NUM_CH - 1);
         grant_id         <= '0;
         gap_cnt          <= '0;
         mux_aux_out      <= '0;
         mux_aux_out_vld  <= 1'b0;
         mux_aux_out_last <= 1'b0;
         abort            <= 1'b0;
      end else begin
         mux_aux_out_vld  <= acc;
         mux_aux_out_last <= acc && ch_last[sel];
         abort            <= timeout;
         gap_cnt          <= (state == LOCKED && !acc && !timeout) ? gap_cnt + GW'(1) : '0;
         if (acc) mux_aux_out <= sel_data;
         if (acc && state == IDLE) begin
            grant_id <= win;
            rr_ptr   <= win;
         end
      end

   assign busy = (state == LOCKED);
endmodule

// File: tb/tb_aux_msg_arbiter_mux.sv
// tb_aux_msg_arbiter_mux: scoreboard bench for the AUX message arbiter mux
module tb_aux_msg_arbiter_mux;
   localparam int DW = 8;
   localparam int NC = 3;
   localparam int SW = 2;
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NC*DW-1:0] ch_data = '0;
   logic [NC-1:0]    ch_vld = '0;
   logic [NC-1:0]    ch_last = '0;
   logic [NC-1:0]    ch_rdy;
   logic             force_en = 1'b0;
   logic [SW-1:0]    force_sel = '0;
   logic [DW-1:0]    mux_aux_out;
   logic             mux_aux_out_vld, mux_aux_out_last, busy, abort;
   logic [SW-1:0]    grant_id;
   int               checks = 0;
   int               errors = 0;
   logic [8:0]       src [NC][$];
   logic [8:0]       sb [$];
   logic [NC-1:0]    rdy_s;

   aux_msg_arbiter_mux #(.DATA_W(DW), .NUM_CH(NC), .GAP_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .ch_data(ch_data), .ch_vld(ch_vld), .ch_last(ch_last),
      .ch_rdy(ch_rdy), .force_en(force_en), .force_sel(force_sel), .mux_aux_out(mux_aux_out),
      .mux_aux_out_vld(mux_aux_out_vld), .mux_aux_out_last(mux_aux_out_last),
      .grant_id(grant_id), .busy(busy), .abort(abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input int ch, input logic last, input logic [7:0] data);
      src[ch].push_back({last, data});
   endtask

   task automatic expect_out(input logic last, input logic [7:0] data);
      sb.push_back({last, data});
   endtask

   // one clock: present source heads, sample ready, pop accepted bytes, score the output
   task automatic cycle();
      logic [8:0] e;
      for (int i = 0; i < NC; i++) begin
         ch_vld[i]  = src[i].size() > 0;
         ch_last[i] = 1'b0;
         ch_data[i*DW +: DW] = '0;
         if (ch_vld[i]) begin
            ch_last[i] = src[i][0][8];
            ch_data[i*DW +: DW] = src[i][0][7:0];
         end
      end
      #1 rdy_s = ch_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < NC; i++)
         if (ch_vld[i] && rdy_s[i]) void'(src[i].pop_front());
      if (mux_aux_out_vld) begin
         if (sb.size() == 0) check("spurious_out", 1, 0);
         else begin
            e = sb.pop_front();
            check("out_data", mux_aux_out, e[7:0]);
            check("out_last", mux_aux_out_last, e[8]);
         end
      end else check("idle_last", mux_aux_out_last, 0);
   endtask

   initial begin
      #3;
      check("rst_vld", mux_aux_out_vld, 0);
      check("rst_data", mux_aux_out, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_abort", abort, 0);
      check("rst_rdy", ch_rdy, 0);
      #9 rst_n = 1'b1;

      // ch0 three-byte message locks out ch1 until it ends, then ch1 follows with no gap
      send(0, 0, 8'hA1); send(0, 0, 8'hA2); send(0, 1, 8'hA3); send(1, 1, 8'hB1);
      expect_out(0, 8'hA1); expect_out(0, 8'hA2); expect_out(1, 8'hA3); expect_out(1, 8'hB1);
      cycle();
      check("s1_busy", busy, 1);
      check("s1_ch1_rdy", rdy_s[1], 0);
      cycle();
      check("s1_ch1_rdy", rdy_s[1], 0);
      cycle();
      check("s1_ch1_rdy", rdy_s[1], 0);
      cycle();
      check("s1_grant", grant_id, 1);
      check("s1_drain", sb.size(), 0);

      // everyone requests single-byte messages: rotate 2,0,1,2,0,1 from rr=1
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NC; i++) send(i, 1, 8'h10 + 8'(i));
      for (int r = 0; r < 2; r++) begin
         expect_out(1, 8'h12); expect_out(1, 8'h10); expect_out(1, 8'h11);
      end
      for (int c = 0; c < 6; c++) begin
         cycle();
         check("s2_busy", busy, 0);
      end
      check("s2_drain", sb.size(), 0);

      // forced select to ch2, switched to ch0 mid-message; ch1 waits for force release
      force_en = 1'b1; force_sel = 2'd2;
      send(0, 1, 8'hC0); send(1, 1, 8'hD0);
      send(2, 0, 8'hE0); send(2, 0, 8'hE1); send(2, 1, 8'hE2);
      expect_out(0, 8'hE0); expect_out(0, 8'hE1); expect_out(1, 8'hE2); expect_out(1, 8'hC0);
      cycle();
      check("s3_grant2", grant_id, 2);
      force_sel = 2'd0;
      for (int c = 0; c < 3; c++) cycle();
      check("s3_grant0", grant_id, 0);
      cycle();
      cycle();
      check("s3_ch1_held", src[1].size(), 1);
      check("s3_drain", sb.size(), 0);
      force_en = 1'b0;
      expect_out(1, 8'hD0);
      cycle();
      check("s3_grant1", grant_id, 1);

      // stalled owner: four idle cycles abort the message, then ch0 is served
      send(1, 0, 8'h55);
      expect_out(0, 8'h55);
      cycle();
      check("s4_busy", busy, 1);
      for (int c = 2; c <= 6; c++) begin
         cycle();
         check("s4_abort", abort, c == 5);
         check("s4_busy", busy, c < 5);
      end
      send(0, 1, 8'h66);
      expect_out(1, 8'h66);
      cycle();
      check("s4_grant", grant_id, 0);
      check("s4_drain", sb.size(), 0);

      // reset mid-message drops it; ch0 has first priority afterwards
      send(2, 0, 8'hF0); send(2, 1, 8'hF1);
      expect_out(0, 8'hF0);
      cycle();
      check("s5_busy", busy, 1);
      #2 rst_n = 1'b0;
      ch_vld = '0;
      src[2].delete();
      #1;
      check("s5_vld", mux_aux_out_vld, 0);
      check("s5_data", mux_aux_out, 0);
      check("s5_busy0", busy, 0);
      check("s5_grant", grant_id, 0);
      check("s5_abort", abort, 0);
      #2 rst_n = 1'b1;
      send(0, 1, 8'h70); send(1, 1, 8'h71); send(2, 1, 8'h72);
      expect_out(1, 8'h70); expect_out(1, 8'h71); expect_out(1, 8'h72);
      for (int c = 0; c < 3; c++) cycle();
      check("s5_drain", sb.size(), 0);

      // out-of-range forced channel: nothing is ever granted
      force_en = 1'b1; force_sel = 2'd3;
      send(0, 1, 8'h77); send(2, 1, 8'h78);
      for (int c = 0; c < 3; c++) begin
         cycle();
         check("s6_rdy", rdy_s, 0);
      end
      check("s6_held", src[0].size() + src[2].size(), 2);
      force_en = 1'b0;
      expect_out(1, 8'h77); expect_out(1, 8'h78);
      cycle();
      cycle();
      check("s6_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
